// File: rtl/ascon_sio_bridge.sv
`default_nettype none
// ascon_sio_bridge: serial MSB-first operand loader and LSB-first result drainer around a parallel Ascon core.
// Revision 1.0
module ascon_sio_bridge #(
  parameter int W       = 1,
  parameter int K       = 128,
  parameter int L       = 40,
  parameter int Y       = 104,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] key_si,
  input  logic [W-1:0] nonce_si,
  input  logic [W-1:0] ad_si,
  input  logic [W-1:0] data_si,
  input  logic         load_en,
  input  logic         start_i,
  input  logic         decrypt_i,
  output logic [K-1:0] core_key,
  output logic [127:0] core_nonce,
  output logic [L-1:0] core_ad,
  output logic [Y-1:0] core_data,
  output logic         core_start,
  output logic         core_decrypt,
  input  logic         core_ready,
  input  logic [Y-1:0] core_out,
  input  logic [127:0] core_tag,
  output logic [W-1:0] data_so,
  output logic [W-1:0] tag_so,
  output logic         so_valid,
  input  logic         so_ready,
  output logic         armed_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int N     = 128;
  localparam int MAX_A = (K > N) ? K : N;
  localparam int MAX_B = (L > MAX_A) ? L : MAX_A;
  localparam int MAX   = (Y > MAX_B) ? Y : MAX_B;
  localparam int CW    = $clog2(MAX + W + 1);
  localparam int NB    = ((Y > N) ? Y : N) / W;
  localparam int BW    = $clog2(NB + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] C_W   = CW'(W);
  localparam logic [CW-1:0] C_K   = CW'(K);
  localparam logic [CW-1:0] C_N   = CW'(N);
  localparam logic [CW-1:0] C_L   = CW'(L);
  localparam logic [CW-1:0] C_Y   = CW'(Y);
  localparam logic [CW-1:0] C_MAX = CW'(MAX);
  localparam logic [BW-1:0] C_DB  = BW'(Y / W);
  localparam logic [BW-1:0] C_TB  = BW'(N / W);
  localparam logic [BW-1:0] C_NBL = BW'(NB - 1);
  localparam logic [TW-1:0] C_TOL = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [K-1:0]  key_q, key_d;
  logic [N-1:0]  nonce_q, nonce_d;
  logic [L-1:0]  ad_q, ad_d;
  logic [Y-1:0]  data_q, data_d;
  logic [Y-1:0]  dsh_q, dsh_d;
  logic [N-1:0]  tsh_q, tsh_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          start_prev_q, start_prev_d;
  logic          core_start_q, core_start_d;
  logic          core_dec_q, core_dec_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic w_rise, w_loading, w_load_beat, w_load_last;
  logic w_start_ok, w_start_err, w_ready, w_timeout, w_beat, w_last_beat;

  assign w_rise      = start_i & ~start_prev_q;
  assign w_loading   = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign w_load_beat = load_en & w_loading;
  assign w_load_last = w_load_beat && ((bit_cnt_q + C_W) >= C_MAX);
  assign w_start_ok  = (state_q == S_ARMED) & w_rise;
  assign w_start_err = w_loading & w_rise;
  assign w_ready     = (state_q == S_RUN) & core_ready;
  assign w_timeout   = (state_q == S_RUN) && !core_ready && (wd_q == C_TOL);
  assign w_beat      = (state_q == S_DRAIN) & so_ready;
  assign w_last_beat = w_beat && (beat_q == C_NBL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_load_beat) state_d = w_load_last ? S_ARMED : S_LOAD;
      S_LOAD:  if (w_load_last) state_d = S_ARMED;
      S_ARMED: if (w_start_ok)  state_d = S_RUN;
      S_RUN: begin
        if (w_ready)        state_d = S_DRAIN;
        else if (w_timeout) state_d = S_IDLE;
      end
      S_DRAIN: if (w_last_beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    armed_o  = (state_q == S_ARMED);
    busy_o   = (state_q == S_RUN) || (state_q == S_DRAIN);
    so_valid = (state_q == S_DRAIN);
    data_so  = '0;
    tag_so   = '0;
    if (state_q == S_DRAIN) begin
      // Each lane falls silent once its own payload has been fully shifted out.
      if (beat_q < C_DB) data_so = dsh_q[W-1:0];
      if (beat_q < C_TB) tag_so  = tsh_q[W-1:0];
    end
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    ad_d         = ad_q;
    data_d       = data_q;
    dsh_d        = dsh_q;
    tsh_d        = tsh_q;
    beat_d       = beat_q;
    wd_d         = wd_q;
    start_prev_d = start_i;
    core_start_d = w_start_ok;
    core_dec_d   = w_start_ok ? decrypt_i : core_dec_q;
    done_d       = w_last_beat;
    err_d        = err_q | w_start_err | w_timeout;

    if (w_load_beat) begin
      bit_cnt_d = bit_cnt_q + C_W;
      if (bit_cnt_q < C_K) key_d   = {key_q[K-W-1:0], key_si};
      if (bit_cnt_q < C_N) nonce_d = {nonce_q[N-W-1:0], nonce_si};
      if (bit_cnt_q < C_L) ad_d    = {ad_q[L-W-1:0], ad_si};
      if (bit_cnt_q < C_Y) data_d  = {data_q[Y-W-1:0], data_si};
    end

    if (w_start_ok) wd_d = '0;
    if (state_q == S_RUN) wd_d = wd_q + 1'b1;
    if (w_ready) begin
      dsh_d = core_out;
      tsh_d = core_tag;
      wd_d  = '0;
    end
    if (w_timeout) begin
      wd_d      = '0;
      bit_cnt_d = '0;
      beat_d    = '0;
    end

    if (w_beat) begin
      dsh_d  = dsh_q >> W;
      tsh_d  = tsh_q >> W;
      beat_d = beat_q + 1'b1;
    end
    if (w_last_beat) begin
      beat_d    = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      key_q        <= '0;
      nonce_q      <= '0;
      ad_q         <= '0;
      data_q       <= '0;
      dsh_q        <= '0;
      tsh_q        <= '0;
      beat_q       <= '0;
      wd_q         <= '0;
      start_prev_q <= 1'b0;
      core_start_q <= 1'b0;
      core_dec_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      ad_q         <= ad_d;
      data_q       <= data_d;
      dsh_q        <= dsh_d;
      tsh_q        <= tsh_d;
      beat_q       <= beat_d;
      wd_q         <= wd_d;
      start_prev_q <= start_prev_d;
      core_start_q <= core_start_d;
      core_dec_q   <= core_dec_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign core_key     = key_q;
  assign core_nonce   = nonce_q;
  assign core_ad      = ad_q;
  assign core_data    = data_q;
  assign core_start   = core_start_q;
  assign core_decrypt = core_dec_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ascon_sio_bridge.sv
`default_nettype none
// tb_ascon_sio_bridge: directed-vector scoreboard bench with a W=1 and a W=4 bridge instance.
module tb_ascon_sio_bridge;

  localparam logic [127:0] KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
  localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
  localparam logic [39:0]  AD    = 40'h4153434f4e;
  localparam logic [103:0] PT    = 104'h6173636f6e2d756e6963617373;
  localparam logic [103:0] CT    = 104'h18490112f8d5867a830748390b;
  localparam logic [127:0] TAG   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam int TO4 = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] key_v, nonce_v;
  logic [39:0]  ad_v;
  logic [103:0] pt_v, dv4, ct_v;
  logic [127:0] tag_v;

  // W=1 instance
  logic         rst1, load1_en, start1, dec1, cs1, cdec1, sv1, arm1, busy1, done1, err1;
  logic [0:0]   key1, nonce1, ad1, data1, so1_d, so1_t;
  logic [127:0] ck1, cn1;
  logic [39:0]  ca1;
  logic [103:0] cd1;

  ascon_sio_bridge #(.W(1)) dut1 (
    .clk(clk), .rst(rst1), .key_si(key1), .nonce_si(nonce1), .ad_si(ad1), .data_si(data1),
    .load_en(load1_en), .start_i(start1), .decrypt_i(dec1),
    .core_key(ck1), .core_nonce(cn1), .core_ad(ca1), .core_data(cd1),
    .core_start(cs1), .core_decrypt(cdec1), .core_ready(1'b0), .core_out(104'h0), .core_tag(128'h0),
    .data_so(so1_d), .tag_so(so1_t), .so_valid(sv1), .so_ready(1'b0),
    .armed_o(arm1), .busy_o(busy1), .done_o(done1), .err_o(err1)
  );

  // W=4 instance
  logic         rst4, load4_en, start4, dec4, cs4, cdec4, sv4, rdy4, arm4, busy4, done4, err4, cr4;
  logic [3:0]   key4, nonce4, ad4, data4, so4_d, so4_t;
  logic [127:0] ck4, cn4, ct4;
  logic [39:0]  ca4;
  logic [103:0] cd4, co4;

  ascon_sio_bridge #(.W(4), .TIMEOUT(TO4)) dut4 (
    .clk(clk), .rst(rst4), .key_si(key4), .nonce_si(nonce4), .ad_si(ad4), .data_si(data4),
    .load_en(load4_en), .start_i(start4), .decrypt_i(dec4),
    .core_key(ck4), .core_nonce(cn4), .core_ad(ca4), .core_data(cd4),
    .core_start(cs4), .core_decrypt(cdec4), .core_ready(cr4), .core_out(co4), .core_tag(ct4),
    .data_so(so4_d), .tag_so(so4_t), .so_valid(sv4), .so_ready(rdy4),
    .armed_o(arm4), .busy_o(busy4), .done_o(done4), .err_o(err4)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cs1_cnt = 0;
  int done4_cnt = 0;
  always @(negedge clk) begin
    if (cs1) cs1_cnt++;
    if (done4) done4_cnt++;
  end

  // Core model: answers each start with CT/TAG a few cycles later unless held off
  logic core_hold;
  initial begin
    cr4 = 1'b0; co4 = '0; ct4 = '0;
    forever begin
      @(negedge clk);
      if (cs4 && !core_hold) begin
        repeat (3) @(posedge clk);
        #1; co4 = CT; ct4 = TAG; cr4 = 1'b1;
        @(posedge clk);
        #1; cr4 = 1'b0; co4 = '0; ct4 = '0;
      end
    end
  end

  // Scoreboard: {data nibble, tag nibble} per expected output beat
  logic [7:0] exp_q[$];
  task automatic push_exp();
    for (int i = 0; i < 32; i++)
      exp_q.push_back({(i < 26) ? ct_v[4*i +: 4] : 4'h0, tag_v[4*i +: 4]});
  endtask

  logic [3:0]   prev_d, prev_t, rx_first;
  logic         prev_stall = 1'b0, prev_valid = 1'b0;
  logic [103:0] rx_ct = '0;
  int           rx_idx = 0;
  logic [7:0]   e;
  always @(negedge clk) begin
    if (sv4 && !prev_valid) begin
      rx_idx = 0;
      rx_ct  = '0;
    end
    if (sv4 && prev_stall) chk("stall_hold", {so4_d, so4_t}, {prev_d, prev_t});
    if (sv4 && rdy4) begin
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("beat%0d", rx_idx), {so4_d, so4_t}, e);
      end
      if (rx_idx == 0) rx_first = so4_d;
      if (rx_idx < 26) rx_ct[4*rx_idx +: 4] = so4_d;
      rx_idx++;
    end
    prev_stall = sv4 && !rdy4;
    prev_valid = sv4;
    prev_d     = so4_d;
    prev_t     = so4_t;
  end

  task automatic load1(input int first, input int last);
    for (int b = first; b <= last; b++) begin
      load1_en = 1'b1;
      key1     = key_v[127-b];
      nonce1   = nonce_v[127-b];
      ad1      = (b < 40)  ? ad_v[39-b]  : 1'b0;
      data1    = (b < 104) ? pt_v[103-b] : 1'b0;
      tick();
    end
    load1_en = 1'b0;
  endtask

  task automatic load4(input int first, input int last);
    for (int b = first; b <= last; b++) begin
      load4_en = 1'b1;
      key4     = key_v[127-4*b -: 4];
      nonce4   = nonce_v[127-4*b -: 4];
      ad4      = (b < 10) ? ad_v[39-4*b -: 4] : 4'h0;
      data4    = (b < 26) ? dv4[103-4*b -: 4] : 4'h0;
      tick();
    end
    load4_en = 1'b0;
  endtask

  task automatic wait_done4(input string name, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done4) break;
    end
    chk(name, i < bound, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  int base, cnt, nb;
  initial begin
    key_v = KEY; nonce_v = NONCE; ad_v = AD; pt_v = PT; ct_v = CT; tag_v = TAG; dv4 = PT;
    rst1 = 1; load1_en = 0; start1 = 0; dec1 = 0; key1 = 0; nonce1 = 0; ad1 = 0; data1 = 0;
    rst4 = 1; load4_en = 0; start4 = 0; dec4 = 0; key4 = 0; nonce4 = 0; ad4 = 0; data4 = 0;
    rdy4 = 0; core_hold = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_armed", arm4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_valid", sv4, 0);
    chk("rst_err_done", {err4, done4, cs4, cdec4}, 0);
    chk("rst_lanes", {so4_d, so4_t}, 0);
    chk("rst_key1", ck1, 0);
    @(posedge clk); #1;
    rst1 = 0; rst4 = 0;

    // W=1: start edge during load is an error, never a core start
    load1(0, 49);
    start1 = 1;
    tick(); tick();
    @(negedge clk);
    chk("early_start_err", err1, 1);
    chk("early_start_no_pulse", cs1_cnt, 0);
    @(posedge clk); #1;
    start1 = 0; rst1 = 1;
    tick();
    rst1 = 0;
    @(negedge clk);
    chk("err_cleared_by_rst", err1, 0);
    @(posedge clk); #1;

    // W=1: full 128-beat load
    load1(0, 126);
    @(negedge clk);
    chk("w1_not_armed_at_127", arm1, 0);
    @(posedge clk); #1;
    load1(127, 127);
    @(negedge clk);
    chk("w1_armed", arm1, 1);
    chk("w1_key", ck1, KEY);
    chk("w1_nonce", cn1, NONCE);
    chk("w1_ad", ca1, AD);
    chk("w1_data", cd1, PT);
    @(posedge clk); #1;
    base = cs1_cnt;
    start1 = 1;
    repeat (6) tick();
    @(negedge clk);
    chk("w1_start_pulses", cs1_cnt - base, 1);
    chk("w1_busy", busy1, 1);
    @(posedge clk); #1;
    start1 = 0;

    // W=4: encrypt, free-running drain
    load4(0, 30);
    @(negedge clk);
    chk("w4_not_armed_at_31", arm4, 0);
    @(posedge clk); #1;
    load4(31, 31);
    @(negedge clk);
    chk("w4_armed", arm4, 1);
    chk("w4_key", ck4, KEY);
    chk("w4_nonce", cn4, NONCE);
    chk("w4_ad", ca4, AD);
    chk("w4_data", cd4, PT);
    @(posedge clk); #1;
    rdy4 = 1; push_exp(); dec4 = 0; start4 = 1;
    tick();
    start4 = 0;
    @(negedge clk);
    chk("w4_core_start", cs4, 1);
    chk("w4_core_decrypt", cdec4, 0);
    @(posedge clk); #1;
    base = done4_cnt;
    wait_done4("w4_done_seen", 200);
    chk("w4_beats", rx_idx, 32);
    chk("w4_first_nibble", rx_first, 4'hb);
    chk("w4_ct", rx_ct, CT);
    chk("w4_queue_empty", exp_q.size(), 0);
    chk("w4_idle_valid", sv4, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w4_done_pulse", done4_cnt - base, 1);
    chk("w4_idle_busy", busy4, 0);
    @(posedge clk); #1;

    // W=4: so_ready stalls 1,0,0,1 during drain
    load4(0, 31);
    push_exp(); start4 = 1;
    tick();
    start4 = 0;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      rdy4 = (i % 4 == 0) || (i % 4 == 3);
      @(negedge clk);
      if (done4) break;
      cnt++;
      @(posedge clk); #1;
    end
    chk("stall_done_seen", cnt < 600, 1);
    chk("stall_beats", rx_idx, 32);
    chk("stall_ct", rx_ct, CT);
    chk("stall_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    rdy4 = 1;

    // W=4: watchdog when the core never answers
    load4(0, 31);
    core_hold = 1; start4 = 1;
    tick();
    start4 = 0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy4) break;
      cnt++;
    end
    chk("timeout_run_cycles", cnt, TO4);
    chk("timeout_err", err4, 1);
    chk("timeout_idle", {arm4, sv4}, 0);
    @(posedge clk); #1;
    core_hold = 0;

    // W=4: reset in the middle of drain, then a decrypt load
    rst4 = 1;
    tick();
    rst4 = 0;
    load4(0, 31);
    push_exp(); start4 = 1;
    tick();
    start4 = 0;
    nb = 0;
    for (int i = 0; i < 200 && nb < 10; i++) begin
      @(negedge clk);
      if (sv4 && rdy4) nb++;
    end
    chk("middrain_reached", nb, 10);
    @(posedge clk); #1;
    rst4 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("middrain_rst_valid", sv4, 0);
    chk("middrain_rst_lanes", {so4_d, so4_t}, 0);
    chk("middrain_rst_status", {arm4, busy4, done4, err4, cs4, cdec4}, 0);
    chk("middrain_rst_key", ck4, 0);
    exp_q.delete();
    rst4 = 0;
    dv4 = CT; dec4 = 1;
    load4(0, 31);
    @(negedge clk);
    chk("dec_armed", arm4, 1);
    chk("dec_data", cd4, CT);
    @(posedge clk); #1;
    push_exp(); start4 = 1;
    tick();
    start4 = 0;
    @(negedge clk);
    chk("dec_core_decrypt", cdec4, 1);
    @(posedge clk); #1;
    wait_done4("dec_done_seen", 200);
    chk("dec_beats", rx_idx, 32);
    chk("dec_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascon_sio_bridge.md
ASCON_SIO_BRIDGE -- requirements
Module: ascon_sio_bridge

Interface
REQ-001 Parameter W, default 1, serial lane width in bits per clock; legal values 1, 2, 4, 8.
REQ-002 Parameter K, default 128, key length in bits; multiple of W.
REQ-003 Parameter L, default 40, associated-data length in bits; multiple of W.
REQ-004 Parameter Y, default 104, plaintext/ciphertext length in bits; multiple of W.
REQ-005 Parameter TIMEOUT, default 4096, maximum RUN cycles before abort.
REQ-006 Reset is synchronous and active-high; the bridge uses a single clock.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 key_si, nonce_si, ad_si, data_si  in  W each  serial load lanes, MSB-first.
REQ-010 load_en  in  1  qualifies one load beat on all four lanes.
REQ-011 start_i  in  1  level request; its rising edge starts the core.
REQ-012 decrypt_i  in  1  mode: 0 encrypt, 1 decrypt.
REQ-013 core_key K, core_nonce 128, core_ad L, core_data Y  out  parallel operands to core.
REQ-014 core_start  out  1  one-cycle start pulse; core_decrypt  out  1  latched mode.
REQ-015 core_ready  in  1; core_out  in  Y; core_tag  in  128  core results.
REQ-016 data_so, tag_so  out  W each  serial result lanes, LSB-first.
REQ-017 so_valid  out  1; so_ready  in  1  output beat handshake.
REQ-018 armed_o, busy_o, done_o, err_o  out  1 each  status.

Function
REQ-019 States: IDLE, LOAD, ARMED, RUN, DRAIN; MAX = max(K,128,L,Y).
REQ-020 IDLE/LOAD: on load_en=1, bit_cnt += W; each register shifts in W bits (MSB-first) only while bit_cnt < its length; IDLE->LOAD on first beat.
REQ-021 bit_cnt reaching MAX -> ARMED, armed_o=1; load_en in ARMED, RUN, DRAIN is ignored.
REQ-022 start_i rising edge (registered previous value) in ARMED -> core_start=1 exactly one cycle, core_decrypt<=decrypt_i, state RUN, busy_o=1.
REQ-023 start_i rising edge in IDLE or LOAD -> ignored, err_o set; err_o sticky until rst.
REQ-024 RUN: core_ready=1 sampled -> next cycle core_out and core_tag captured into output shifters, state DRAIN, so_valid=1.
REQ-025 RUN watchdog: TIMEOUT cycles without core_ready -> err_o=1, state IDLE, all counters cleared.
REQ-026 DRAIN: beat completes when so_valid and so_ready both 1; shifters advance W bits, LSB-first; so_ready=0 holds data_so/tag_so stable.
REQ-027 data_so valid for Y/W beats, then drives 0; tag_so valid for 128/W beats, then drives 0.
REQ-028 After max(Y,128)/W beats -> IDLE, so_valid=0, busy_o=0, done_o=1 for one cycle, load counters cleared.
REQ-029 Operand registers retain contents after DRAIN until next load beat overwrites them.
REQ-030 core_start and load beat never coincide; core_ready outside RUN is ignored.

Reset
REQ-031 rst=1 at any cycle (including mid-RUN or mid-DRAIN) -> next edge: state IDLE, all shifters and counters 0, core_start/core_decrypt/so_valid/armed_o/busy_o/done_o/err_o/data_so/tag_so = 0.
REQ-032 First load beat accepted on the cycle after rst deasserts.

Verification
REQ-033 W=1: load KEY 6d4f8bbf60ec05a07b201d4e5b2119ac, NONCE 05885e606e1271b8d47a74c7b297a318, AD 4153434f4e, PT 6173636f6e2d756e6963617373 over 128 beats -> armed_o=1 after beat 128, core_* equal the vectors; start edge -> single core_start pulse.
REQ-034 W=4 same vectors -> armed after 32 beats; core model returns CT 18490112f8d5867a830748390b -> 26 valid data beats, LSB nibble first (b), 32 tag beats, done_o pulse.
REQ-035 DRAIN with so_ready toggling 1,0,0,1 -> outputs held during stall, total valid beats unchanged, reassembled CT exact.
REQ-036 start_i rising at beat 50 of load -> err_o=1, no core_start; core held not ready TIMEOUT cycles after valid start -> err_o=1, state IDLE.
REQ-037 rst asserted mid-DRAIN at beat 10 -> all outputs 0 next cycle; fresh decrypt load with CT then yields core_decrypt=1.
